// File: rtl/clock_set_core_gen2.sv
// Timekeeping and set-mode core for the 7-seg digital clock.
// Keeps BCD HH:MM:SS advanced by a 1 Hz prescaler, lets the user edit a shadow
// copy of the time with inc/dec keys (with auto-repeat), and maps the shown
// hour to 12 h form on request. Internal time is always 24 h BCD.
module clock_set_core_gen2 #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned REPEAT_DLY  = 25_000_000,
    parameter int unsigned REPEAT_RATE = 5_000_000,
    parameter logic [7:0]  RST_HH      = 8'h16,
    parameter logic [7:0]  RST_MM      = 8'h25,
    parameter logic [7:0]  RST_SS      = 8'h00
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       btn_set,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       mode_12h,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic [7:0] disp_ss,
    output logic       pm,
    output logic       set_en,
    output logic [1:0] blink_sel,
    output logic       blink_on,
    output logic       tick_1hz
);

    localparam int unsigned PRESC_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned BLINK_TC = (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
    localparam int unsigned BLINK_W  = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;
    localparam int unsigned RPT_W    = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TC - 1);
    localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0]   RPT_RELOAD = RPT_W'(REPEAT_DLY - REPEAT_RATE);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_t;

    // BCD increment that wraps from maxv back to 00.
    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement that wraps from 00 to maxv; x0 borrows to (x-1)9.
    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] maxv);
        if (v == 8'h00)          return maxv;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    state_t             state_q;
    logic [3:0]         btnCur_q, btnPrev_q;
    logic [7:0]         liveHh_q, liveMm_q, liveSs_q;
    logic [7:0]         shHh_q, shMm_q, shSs_q;
    logic [PRESC_W-1:0] presc_q;
    logic [BLINK_W-1:0] blinkCnt_q;
    logic               blinkOn_q;
    logic               tick_q;
    logic               setEn_q;
    logic [1:0]         blinkSel_q;
    logic [RPT_W-1:0]   rptCnt_q;
    logic               rptArmed_q;

    logic       setRise, selRise, incLvl, decLvl, keyRise, rptFire, doStep;
    logic [7:0] fieldCur, fieldMax, fieldNext_d;
    logic [7:0] hh24;

    // Button edge detection, repeat timing and the value the current field would take.
    always_comb begin
        setRise  = btnCur_q[0] & ~btnPrev_q[0];
        selRise  = btnCur_q[1] & ~btnPrev_q[1];
        incLvl   = btnCur_q[2] & ~btnCur_q[3];
        decLvl   = btnCur_q[3] & ~btnCur_q[2];
        keyRise  = (incLvl & ~btnPrev_q[2]) | (decLvl & ~btnPrev_q[3]);
        rptFire  = rptArmed_q & (incLvl | decLvl) & (rptCnt_q == RPT_LAST);
        doStep   = keyRise | rptFire;
        fieldCur = shSs_q;
        fieldMax = 8'h59;
        case (state_q)
            SET_HH: begin fieldCur = shHh_q; fieldMax = 8'h23; end
            SET_MM: begin fieldCur = shMm_q; fieldMax = 8'h59; end
            default: ;
        endcase
        fieldNext_d = incLvl ? bcdInc(fieldCur, fieldMax) : bcdDec(fieldCur, fieldMax);
    end

    // Register each button once so rises are seen on clean synchronous levels.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            btnCur_q  <= 4'b0000;
            btnPrev_q <= 4'b0000;
        end else begin
            btnCur_q  <= {btn_dec, btn_inc, btn_sel, btn_set};
            btnPrev_q <= btnCur_q;
        end
    end

    // Free-running 2 Hz blink square wave, independent of mode.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt_q <= '0;
            blinkOn_q  <= 1'b1;
        end else if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_q <= '0;
            blinkOn_q  <= ~blinkOn_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + BLINK_W'(1);
        end
    end

    // Main FSM: timekeeping in RUN, shadow editing with auto-repeat in the SET states.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            liveHh_q   <= RST_HH;
            liveMm_q   <= RST_MM;
            liveSs_q   <= RST_SS;
            shHh_q     <= 8'h00;
            shMm_q     <= 8'h00;
            shSs_q     <= 8'h00;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            setEn_q    <= 1'b0;
            blinkSel_q <= 2'b11;
            rptCnt_q   <= '0;
            rptArmed_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (state_q == RUN) begin
                rptCnt_q   <= '0;
                rptArmed_q <= 1'b0;
                if (setRise) begin
                    state_q    <= SET_HH;
                    shHh_q     <= liveHh_q;
                    shMm_q     <= liveMm_q;
                    shSs_q     <= liveSs_q;
                    setEn_q    <= 1'b1;
                    blinkSel_q <= 2'b00;
                end else if (presc_q == PRESC_LAST) begin
                    presc_q  <= '0;
                    tick_q   <= 1'b1;
                    liveSs_q <= bcdInc(liveSs_q, 8'h59);
                    if (liveSs_q == 8'h59) begin
                        liveMm_q <= bcdInc(liveMm_q, 8'h59);
                        if (liveMm_q == 8'h59)
                            liveHh_q <= bcdInc(liveHh_q, 8'h23);
                    end
                end else begin
                    presc_q <= presc_q + PRESC_W'(1);
                end
            end else if (setRise) begin
                state_q    <= RUN;
                liveHh_q   <= shHh_q;
                liveMm_q   <= shMm_q;
                liveSs_q   <= shSs_q;
                presc_q    <= '0;
                setEn_q    <= 1'b0;
                blinkSel_q <= 2'b11;
                rptCnt_q   <= '0;
                rptArmed_q <= 1'b0;
            end else if (selRise) begin
                rptCnt_q   <= '0;
                rptArmed_q <= 1'b0;
                case (state_q)
                    SET_HH:  begin state_q <= SET_MM; blinkSel_q <= 2'b01; end
                    SET_MM:  begin state_q <= SET_SS; blinkSel_q <= 2'b10; end
                    default: begin state_q <= SET_HH; blinkSel_q <= 2'b00; end
                endcase
            end else begin
                if (keyRise) begin
                    rptCnt_q   <= '0;
                    rptArmed_q <= 1'b1;
                end else if (rptArmed_q && (incLvl || decLvl)) begin
                    rptCnt_q <= (rptCnt_q == RPT_LAST) ? RPT_RELOAD : rptCnt_q + RPT_W'(1);
                end else begin
                    rptCnt_q   <= '0;
                    rptArmed_q <= 1'b0;
                end
                if (doStep) begin
                    case (state_q)
                        SET_HH:  shHh_q <= fieldNext_d;
                        SET_MM:  shMm_q <= fieldNext_d;
                        default: shSs_q <= fieldNext_d;
                    endcase
                end
            end
        end
    end

    // Display source select and 12 h hour mapping (display only).
    always_comb begin
        hh24    = (state_q == RUN) ? liveHh_q : shHh_q;
        disp_mm = (state_q == RUN) ? liveMm_q : shMm_q;
        disp_ss = (state_q == RUN) ? liveSs_q : shSs_q;
        disp_hh = hh24;
        pm      = 1'b0;
        if (mode_12h) begin
            pm = (hh24 >= 8'h12);
            if (hh24 == 8'h00)
                disp_hh = 8'h12;
            else if (hh24 > 8'h12) begin
                if (hh24[7:4] == 4'd1)
                    disp_hh = {4'd0, hh24[3:0] - 4'd2};
                else if (hh24[3:0] < 4'd2)
                    disp_hh = {4'd0, hh24[3:0] + 4'd8};
                else
                    disp_hh = {4'd1, hh24[3:0] - 4'd2};
            end
        end
    end

    assign set_en    = setEn_q;
    assign blink_sel = blinkSel_q;
    assign blink_on  = blinkOn_q;
    assign tick_1hz  = tick_q;

endmodule
